conv_window_streamer: RTL and testbench

CONV_WINDOW_STREAMER -- requirements
Module: conv_window_streamer

---
 rtl/conv_window_streamer_if.sv | 29 ++
 rtl/conv_window_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_conv_window_streamer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/conv_window_streamer_if.sv
// Stream bundle for conv_window_streamer.
//   in_*        : input pixel stream (one channel word per beat, raster order)
//   win_*       : window stream, K*K words per beat, element (i,j) at [(i*K+j)*N +: N]
//   channel_out/row_out/col_out : tags of the window currently on win_data
// The slave modport is the streamer's view; the master modport is the environment's.
interface conv_window_streamer_if #(
    parameter int N = 16,
    parameter int K = 3
);
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [K*K*N-1:0] win_data;
    logic             win_valid;
    logic             win_ready;
    logic [7:0]       channel_out;
    logic [7:0]       row_out;
    logic [7:0]       col_out;

    modport slave (
        input  in_data, in_valid, win_ready,
        output in_ready, win_data, win_valid, channel_out, row_out, col_out
    );

    modport master (
        output in_data, in_valid, win_ready,
        input  in_ready, win_data, win_valid, channel_out, row_out, col_out
    );
endinterface

// File: rtl/conv_window_streamer.sv
// Sliding-window streamer: accepts a raster-ordered image (channels interleaved
// per pixel) and emits zero-padded KxK windows at stride S, one per channel,
// ordered row_out, col_out, channel_out.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   start : one-cycle pulse starting a frame (ignored while busy)
//   busy  : high from the accepted start through the done cycle
//   done  : one-cycle pulse after the last window handshake
//   io    : in_* input stream and win_* window stream with tags
//
// state  | meaning
// IDLE   | waiting for start, in_ready low
// FILL   | accepting input, no window produced yet
// STREAM | accepting input and emitting windows
// FLUSH  | all input received, emitting remaining windows
// DONE   | single cycle, done pulse
module conv_window_streamer #(
    parameter int N           = 16,
    parameter int IMG_W       = 224,
    parameter int IMG_H       = 224,
    parameter int K           = 3,
    parameter int S           = 2,
    parameter int P           = 1,
    parameter int IN_CHANNELS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_window_streamer_if.slave io
);
    localparam int OH     = (IMG_H + 2 * P - K) / S + 1;
    localparam int OW     = (IMG_W + 2 * P - K) / S + 1;
    localparam int LINE   = IMG_W * IN_CHANNELS;
    localparam int AW     = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int SW     = (K > 1) ? $clog2(K) : 1;
    // Line slot holding the top window row (row_out*S-P) mod K; starts at (-P) mod K.
    localparam int GSLOT0 = (K - P) % K;
    localparam int SSTEP  = S % K;

    typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       in_y_q, in_y_d;
    logic [AW-1:0]    in_addr_q, in_addr_d;
    logic [SW-1:0]    in_slot_q, in_slot_d;
    logic             in_done_q, in_done_d;
    logic [7:0]       gen_r_q, gen_r_d;
    logic [7:0]       gen_c_q, gen_c_d;
    logic [7:0]       gen_ch_q, gen_ch_d;
    logic [SW-1:0]    gen_slot_q, gen_slot_d;
    logic             gen_done_q, gen_done_d;
    logic             win_valid_q, win_valid_d;
    logic [K*K*N-1:0] win_data_q, win_data_d;
    logic [7:0]       chan_q, chan_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;

    // K rotating lines: K-1 history lines plus the one being written.
    logic [N-1:0]     line_mem [K][LINE];

    logic [K*K*N-1:0] win_next;
    logic             avail;
    logic             room;
    logic [SW-1:0]    gen_slot_nx;
    logic             in_ready_c;
    logic             in_hs;
    logic             load;
    int               ylo, xlo, ybot, xr, wy, wx, wsl, wad, nsl;

    // Window assembly, availability of the next window and line-overwrite guard.
    always_comb begin
        win_next = '0;
        ylo  = int'(gen_r_q) * S - P;
        xlo  = int'(gen_c_q) * S - P;
        ybot = ylo + K - 1;
        if (ybot > IMG_H - 1) ybot = IMG_H - 1;
        xr = xlo + K - 1;
        if (xr > IMG_W - 1) xr = IMG_W - 1;
        // Ready once the raster position of the last in-range pixel it needs has passed.
        avail = in_done_q || (int'(in_y_q) > ybot) ||
                ((int'(in_y_q) == ybot) &&
                 (int'(in_addr_q) > xr * IN_CHANNELS + int'(gen_ch_q)));
        // Writing row y reuses the slot of row y-K; allow only rows below ylo+K.
        room = gen_done_q || (int'(in_y_q) + P < int'(gen_r_q) * S + K);
        nsl = int'(gen_slot_q) + SSTEP;
        if (nsl >= K) nsl = nsl - K;
        gen_slot_nx = SW'(nsl);
        wy  = 0;
        wx  = 0;
        wsl = 0;
        wad = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                wy  = ylo + i;
                wx  = xlo + j;
                wsl = int'(gen_slot_q) + i;
                if (wsl >= K) wsl = wsl - K;
                wad = wx * IN_CHANNELS + int'(gen_ch_q);
                if (wy >= 0 && wy < IMG_H && wx >= 0 && wx < IMG_W)
                    win_next[(i*K+j)*N +: N] = line_mem[SW'(wsl)][AW'(wad)];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        in_y_d      = in_y_q;
        in_addr_d   = in_addr_q;
        in_slot_d   = in_slot_q;
        in_done_d   = in_done_q;
        gen_r_d     = gen_r_q;
        gen_c_d     = gen_c_q;
        gen_ch_d    = gen_ch_q;
        gen_slot_d  = gen_slot_q;
        gen_done_d  = gen_done_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        chan_d      = chan_q;
        row_d       = row_q;
        col_d       = col_q;

        in_ready_c = ((state_q == FILL) || (state_q == STREAM)) && !in_done_q && room;
        in_hs      = in_ready_c && io.in_valid;
        load       = ((state_q == FILL) || (state_q == STREAM) || (state_q == FLUSH)) &&
                     !gen_done_q && avail && (!win_valid_q || io.win_ready);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FILL;
                    in_y_d      = '0;
                    in_addr_d   = '0;
                    in_slot_d   = '0;
                    in_done_d   = 1'b0;
                    gen_r_d     = '0;
                    gen_c_d     = '0;
                    gen_ch_d    = '0;
                    gen_slot_d  = SW'(GSLOT0);
                    gen_done_d  = 1'b0;
                    win_valid_d = 1'b0;
                end
            end
            FILL:   if (load) state_d = STREAM;
            STREAM: if (in_done_q) state_d = FLUSH;
            FLUSH:  if (gen_done_q && (!win_valid_q || io.win_ready)) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (in_hs) begin
            if (in_addr_q == AW'(LINE - 1)) begin
                in_addr_d = '0;
                in_slot_d = (in_slot_q == SW'(K - 1)) ? '0 : in_slot_q + SW'(1);
                if (in_y_q == 8'(IMG_H - 1)) in_done_d = 1'b1;
                else                         in_y_d    = in_y_q + 8'd1;
            end else begin
                in_addr_d = in_addr_q + AW'(1);
            end
        end

        if (load) begin
            win_valid_d = 1'b1;
            win_data_d  = win_next;
            chan_d      = gen_ch_q;
            row_d       = gen_r_q;
            col_d       = gen_c_q;
            if (gen_ch_q == 8'(IN_CHANNELS - 1)) begin
                gen_ch_d = '0;
                if (gen_c_q == 8'(OW - 1)) begin
                    gen_c_d = '0;
                    if (gen_r_q == 8'(OH - 1)) begin
                        gen_done_d = 1'b1;
                    end else begin
                        gen_r_d    = gen_r_q + 8'd1;
                        gen_slot_d = gen_slot_nx;
                    end
                end else begin
                    gen_c_d = gen_c_q + 8'd1;
                end
            end else begin
                gen_ch_d = gen_ch_q + 8'd1;
            end
        end else if (win_valid_q && io.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_y_q      <= '0;
            in_addr_q   <= '0;
            in_slot_q   <= '0;
            in_done_q   <= 1'b0;
            gen_r_q     <= '0;
            gen_c_q     <= '0;
            gen_ch_q    <= '0;
            gen_slot_q  <= '0;
            gen_done_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            chan_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_y_q      <= in_y_d;
            in_addr_q   <= in_addr_d;
            in_slot_q   <= in_slot_d;
            in_done_q   <= in_done_d;
            gen_r_q     <= gen_r_d;
            gen_c_q     <= gen_c_d;
            gen_ch_q    <= gen_ch_d;
            gen_slot_q  <= gen_slot_d;
            gen_done_q  <= gen_done_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            chan_q      <= chan_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    // Line storage carries no reset; stale contents are never read because
    // availability and the zero-padding test gate every access.
    always_ff @(posedge clk) begin
        if (in_hs) line_mem[in_slot_q][in_addr_q] <= io.in_data;
    end

    assign io.in_ready    = in_ready_c;
    assign io.win_valid   = win_valid_q;
    assign io.win_data    = win_data_q;
    assign io.channel_out = chan_q;
    assign io.row_out     = row_q;
    assign io.col_out     = col_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_conv_window_streamer.sv
module tb_conv_window_streamer;
    localparam int ND = 4;
    // 0: 4x4 K3 S1 P1 CH1   1: 4x4 K3 S1 P1 CH2   2: 4x4 K1 S1 P0   3: 8x8 K3 S2 P1
    localparam int C_W[ND] = '{4, 4, 4, 8};
    localparam int C_H[ND] = '{4, 4, 4, 8};
    localparam int C_K[ND] = '{3, 3, 1, 3};
    localparam int C_S[ND] = '{1, 1, 1, 2};
    localparam int C_P[ND] = '{1, 1, 0, 1};
    localparam int C_C[ND] = '{1, 2, 1, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ND-1:0] start_v, dvalid, wrdy;
    logic [15:0]   din [ND];
    wire  [ND-1:0] drdy, wvalid, busy_v, done_v;
    wire  [143:0]  wdata [ND];
    wire  [7:0]    wch [ND];
    wire  [7:0]    wrow [ND];
    wire  [7:0]    wcol [ND];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        conv_window_streamer_if #(.N(16), .K(C_K[g])) ifc ();
        assign ifc.in_data   = din[g];
        assign ifc.in_valid  = dvalid[g];
        assign ifc.win_ready = wrdy[g];
        assign drdy[g]       = ifc.in_ready;
        assign wvalid[g]     = ifc.win_valid;
        assign wdata[g]      = 144'(ifc.win_data);
        assign wch[g]        = ifc.channel_out;
        assign wrow[g]       = ifc.row_out;
        assign wcol[g]       = ifc.col_out;
        conv_window_streamer #(
            .N(16), .IMG_W(C_W[g]), .IMG_H(C_H[g]), .K(C_K[g]), .S(C_S[g]),
            .P(C_P[g]), .IN_CHANNELS(C_C[g])
        ) dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy_v[g]),
            .done(done_v[g]), .io(ifc)
        );
    end

    function automatic logic [15:0] pix(input int d, input int y, input int x, input int c);
        if (d == 3) return 16'h0100;
        return 16'(y * 4 + x + 1 + 100 * c);
    endfunction

    function automatic logic [143:0] exp_win(input int d, input int r, input int c, input int ch);
        logic [143:0] w;
        int y, x;
        w = '0;
        for (int i = 0; i < C_K[d]; i++)
            for (int j = 0; j < C_K[d]; j++) begin
                y = r * C_S[d] - C_P[d] + i;
                x = c * C_S[d] - C_P[d] + j;
                if (y >= 0 && y < C_H[d] && x >= 0 && x < C_W[d])
                    w[(i*C_K[d]+j)*16 +: 16] = pix(d, y, x, ch);
            end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  144'(drdy[0]),   144'd0);
        chk({tag, "_win_valid"}, 144'(wvalid[0]), 144'd0);
        chk({tag, "_busy"},      144'(busy_v[0]), 144'd0);
        chk({tag, "_done"},      144'(done_v[0]), 144'd0);
        chk({tag, "_win_data"},  wdata[0],        144'd0);
        chk({tag, "_tags"},      144'({wch[0], wrow[0], wcol[0]}), 144'd0);
    endtask

    // Runs one frame on DUT d; rnd randomises in_valid/win_ready, abort_at > 0
    // returns after that many windows, poke pulses start mid-frame.
    task automatic run_frame(input int d, input bit rnd, input int abort_at, input bit poke);
        int oh, ow, tot_in, tot_win, n_in, n_win, er, ec, ech, cyc, done_cnt, tail;
        bit stalled;
        logic [143:0] held_d;
        logic [23:0]  held_t;
        oh = (C_H[d] + 2 * C_P[d] - C_K[d]) / C_S[d] + 1;
        ow = (C_W[d] + 2 * C_P[d] - C_K[d]) / C_S[d] + 1;
        tot_in  = C_H[d] * C_W[d] * C_C[d];
        tot_win = oh * ow * C_C[d];
        n_in = 0; n_win = 0; er = 0; ec = 0; ech = 0; cyc = 0; done_cnt = 0; tail = -1;
        stalled = 1'b0; held_d = '0; held_t = '0;
        @(negedge clk); start_v[d] = 1'b1;
        @(negedge clk); start_v[d] = 1'b0;
        chk($sformatf("busy_after_start_d%0d", d), 144'(busy_v[d]), 144'd1);
        while (cyc < 3000 && tail != 0 && !(abort_at > 0 && n_win >= abort_at)) begin
            dvalid[d]  = (n_in < tot_in) && (!rnd || $urandom_range(0, 1) == 1);
            din[d]     = pix(d, n_in / (C_C[d] * C_W[d]), (n_in / C_C[d]) % C_W[d], n_in % C_C[d]);
            wrdy[d]    = !rnd || $urandom_range(0, 1) == 1;
            start_v[d] = poke && (n_win == 5);
            #1;
            if (stalled) begin
                chk($sformatf("stall_valid_d%0d", d), 144'(wvalid[d]), 144'd1);
                chk($sformatf("stall_data_d%0d", d), wdata[d], held_d);
                chk($sformatf("stall_tags_d%0d", d), 144'({wch[d], wrow[d], wcol[d]}), 144'(held_t));
            end
            if (wvalid[d] && wrdy[d]) begin
                chk($sformatf("win_d%0d_r%0d_c%0d_ch%0d", d, er, ec, ech), wdata[d], exp_win(d, er, ec, ech));
                chk($sformatf("tags_d%0d_n%0d", d, n_win), 144'({wch[d], wrow[d], wcol[d]}),
                    144'({8'(ech), 8'(er), 8'(ec)}));
                n_win++;
                ech++;
                if (ech == C_C[d]) begin
                    ech = 0;
                    ec++;
                    if (ec == ow) begin ec = 0; er++; end
                end
            end
            stalled = wvalid[d] && !wrdy[d];
            held_d  = wdata[d];
            held_t  = {wch[d], wrow[d], wcol[d]};
            if (dvalid[d] && drdy[d]) n_in++;
            if (done_v[d]) begin
                done_cnt++;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            cyc++;
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        dvalid[d]  = 1'b0;
        wrdy[d]    = 1'b0;
        if (abort_at == 0) begin
            chk($sformatf("no_timeout_d%0d", d), 144'(cyc < 3000), 144'd1);
            chk($sformatf("win_count_d%0d", d), 144'(n_win), 144'(tot_win));
            chk($sformatf("in_count_d%0d", d), 144'(n_in), 144'(tot_in));
            chk($sformatf("done_pulses_d%0d", d), 144'(done_cnt), 144'd1);
            chk($sformatf("busy_after_done_d%0d", d), 144'(busy_v[d]), 144'd0);
        end
    endtask

    initial begin
        start_v = '0;
        dvalid  = '0;
        wrdy    = '0;
        din     = '{default: '0};
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_frame(0, 1'b0, 0, 1'b0);   // 4x4 K3 S1 P1 basic
        run_frame(1, 1'b0, 0, 1'b0);   // two interleaved channels
        run_frame(2, 1'b0, 0, 1'b0);   // K=1: windows equal input stream
        run_frame(3, 1'b0, 0, 1'b0);   // stride 2, constant image
        run_frame(0, 1'b1, 0, 1'b0);   // random stalls on both sides
        run_frame(0, 1'b0, 0, 1'b1);   // start pulsed mid-frame is ignored

        run_frame(0, 1'b0, 7, 1'b0);   // abort after 7th window
        rst = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        chk("abort_no_done", 144'(done_v[0]), 144'd0);
        rst = 1'b1;
        run_frame(0, 1'b0, 0, 1'b0);   // fresh frame after abort

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
